seq_detector_param: RTL
=======================

Name: seq_detector_param

Overview:
Parametrised serial pattern detector, the successor to the fixed 101001 detector. The pattern, its length (1..MAX_LEN) and the overlap mode are run-time programmable. Adds an input enable, a registered match pulse and a saturating match counter. Sits on a 1-bit serial data stream in the i_clk domain; outputs feed status/interrupt logic.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (>=2)
LEN_W, 4, width of length field; must satisfy 2**LEN_W > MAX_LEN
CNT_WIDTH, 8, width of saturating match counter
DEF_PATTERN, 8'b0010_1001, reset pattern (low DEF_LEN bits used)
DEF_LEN, 6, reset pattern length
DEF_OVERLAP, 1, reset overlap mode (1 = overlapping matches allowed)

Ports:
i_clk  in  1  clock, rising edge
i_resetn  in  1  asynchronous active-low reset
i_en  in  1  sample i_data this cycle
i_data  in  1  serial data bit
i_cfg_load  in  1  latch configuration inputs this cycle
i_cfg_pattern  in  MAX_LEN  pattern; bit [len-1] received first, bit [0] last
i_cfg_len  in  LEN_W  pattern length
i_cfg_overlap  in  1  overlap mode
i_clr_count  in  1  synchronous clear of match counter
o_pattern_found  out  1  one-cycle match pulse, registered
o_match_count  out  CNT_WIDTH  number of matches, saturating
o_count_sat  out  1  high while o_match_count == all ones

Behaviour:
- Reset (async, i_resetn low): history=0, fill=0, pattern=DEF_PATTERN, len=DEF_LEN, overlap=DEF_OVERLAP, o_pattern_found=0, o_match_count=0, o_count_sat=0.
- State: history shift register hist[MAX_LEN-1:0] (hist[0] newest) and fill counter 0..MAX_LEN (valid bits held).
- Enabled cycle (i_en=1, i_cfg_load=0): h' = {hist[MAX_LEN-2:0], i_data}; fill' = min(fill+1, MAX_LEN); match = (len!=0) && (fill' >= len) && (h'[len-1:0] == pattern[len-1:0]).
- On the edge: hist<=h'. fill<=fill', except fill<=0 when match && overlap==0. o_pattern_found<=match.
- Latency: o_pattern_found goes high for exactly one cycle, on the cycle after the edge that sampled the final pattern bit.
- i_en=0: hist and fill hold. o_pattern_found<=0. Idle cycles inside a pattern do not break it.
- i_cfg_load=1 (priority over i_en): latch pattern, len and overlap. hist<=0, fill<=0, o_pattern_found<=0. i_data is ignored that cycle. The counter is unaffected.
- Length rules: len=0 never matches. A loaded i_cfg_len > MAX_LEN is clamped to MAX_LEN. len=1 matches on every sample equal to pattern[0].
- Counter: increments on each match. It holds at all ones, with no wrap. i_clr_count sets it to 0 and wins over a simultaneous match; the o_pattern_found pulse still fires.
- o_count_sat is combinational from o_match_count.
- Reset mid-pattern: a partial match is discarded and the configuration returns to the defaults.

Test Plan:
- Default config, i_en=1, stream 1,0,1,0,0,1 -> o_pattern_found pulses once, on the cycle after the 6th bit; count=1.
- Overlap=1, stream 1,0,1,0,0,1,0,1,0,0,1 -> pulses after bits 6 and 11; count=2. Same stream after loading overlap=0 -> single pulse after bit 6; count=1.
- Stream 1,0,1 then i_en=0 for 3 cycles, then 0,0,1 -> one pulse, after the final 1.
- Load pattern=8'b0000_0011, len=2, overlap=1; stream 1,1,1,1 -> pulses after bits 2, 3 and 4. Load with len=0 -> no pulses on any stream. Load with len=12 -> behaves as len=8.
- CNT_WIDTH=2, generate 5 matches -> count sequence 1,2,3,3,3; o_count_sat high from the 3rd match. Pulse i_clr_count together with a match -> count=0.
- Assert i_resetn low after 1,0,1,0,0 -> all outputs 0 and default config restored. Then 1 alone -> no pulse; full 1,0,1,0,0,1 -> pulse.

Source files
------------

// File: rtl/seq_detector_param_if.sv
`default_nettype none
// ============================================================================
// seq_detector_param_if : serial data, configuration and status bundle
// Revision: 1.0
// ============================================================================
interface seq_detector_param_if #(
   parameter int MAX_LEN   = 8,
   parameter int LEN_W     = 4,
   parameter int CNT_WIDTH = 8
);
   logic                 i_en;
   logic                 i_data;
   logic                 i_cfg_load;
   logic [MAX_LEN-1:0]   i_cfg_pattern;
   logic [LEN_W-1:0]     i_cfg_len;
   logic                 i_cfg_overlap;
   logic                 i_clr_count;
   logic                 o_pattern_found;
   logic [CNT_WIDTH-1:0] o_match_count;
   logic                 o_count_sat;

   modport master (
      output i_en, i_data, i_cfg_load, i_cfg_pattern, i_cfg_len,
             i_cfg_overlap, i_clr_count,
      input  o_pattern_found, o_match_count, o_count_sat
   );

   modport slave (
      input  i_en, i_data, i_cfg_load, i_cfg_pattern, i_cfg_len,
             i_cfg_overlap, i_clr_count,
      output o_pattern_found, o_match_count, o_count_sat
   );
endinterface
`default_nettype wire

// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
// seq_detector_param : run-time programmable serial pattern detector
// Revision: 1.0
// ============================================================================
module seq_detector_param #(
   parameter int                 MAX_LEN     = 8,
   parameter int                 LEN_W       = 4,
   parameter int                 CNT_WIDTH   = 8,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0010_1001),
   parameter int                 DEF_LEN     = 6,
   parameter bit                 DEF_OVERLAP = 1'b1
) (
   input  logic               i_clk,
   input  logic               i_resetn,
   seq_detector_param_if.slave bus
);
   localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

   logic [MAX_LEN-1:0]   hist;
   logic [MAX_LEN-1:0]   hist_next;
   logic [MAX_LEN-1:0]   pattern;
   logic [MAX_LEN-1:0]   len_mask;
   logic [LEN_W-1:0]     len;
   logic [LEN_W-1:0]     fill;
   logic [LEN_W-1:0]     fill_next;
   logic [LEN_W-1:0]     cfg_len;
   logic                 overlap;
   logic                 match;
   logic                 found;
   logic [CNT_WIDTH-1:0] count;

   always_comb begin
      hist_next = {hist[MAX_LEN-2:0], bus.i_data};
      fill_next = (fill == LEN_MAX) ? fill : fill + LEN_W'(1);
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (LEN_W'(i) < len);
      end
      // Only the newest len bits take part; fill guards against matching on reset zeros.
      match   = bus.i_en && !bus.i_cfg_load && (len != '0) && (fill_next >= len) &&
                (((hist_next ^ pattern) & len_mask) == '0);
      cfg_len = (bus.i_cfg_len > LEN_MAX) ? LEN_MAX : bus.i_cfg_len;
   end

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         hist    <= '0;
         fill    <= '0;
         pattern <= DEF_PATTERN;
         len     <= LEN_W'(DEF_LEN);
         overlap <= DEF_OVERLAP;
         found   <= 1'b0;
         count   <= '0;
      end else begin
         found <= match;
         if (bus.i_cfg_load) begin
            pattern <= bus.i_cfg_pattern;
            len     <= cfg_len;
            overlap <= bus.i_cfg_overlap;
            hist    <= '0;
            fill    <= '0;
         end else if (bus.i_en) begin
            hist <= hist_next;
            fill <= (match && !overlap) ? '0 : fill_next;
         end
         if (bus.i_clr_count) begin
            count <= '0;
         end else if (match && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
         end
      end
   end

   assign bus.o_pattern_found = found;
   assign bus.o_match_count   = count;
   assign bus.o_count_sat     = (count == '1);
endmodule
`default_nettype wire
